// File: rtl/pr_alloc_ctrl_pkg.sv
// pr_alloc_ctrl_pkg: shared rename constants, FSM state type and modulo-48 pointer arithmetic.
package pr_alloc_ctrl_pkg;
    localparam int NUM_FREE_PR = 48;
    localparam int ALLOC_WIDTH = 4;
    localparam int NUM_CKPT = 4;
    localparam int PTR_W = 7;
    localparam int TAG_W = 2;
    typedef enum logic {RUN, RECOVER} state_e;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0] psum_t;
    function automatic ptr_t ptr_mod(input ptr_t a, input ptr_t b, input logic sub);
        psum_t s;
        s = sub ? psum_t'(a) + psum_t'(NUM_FREE_PR) - psum_t'(b) : psum_t'(a) + psum_t'(b);
        return s >= psum_t'(NUM_FREE_PR) ? ptr_t'(s - psum_t'(NUM_FREE_PR)) : ptr_t'(s);
    endfunction
endpackage

// File: rtl/pr_alloc_ctrl_if.sv
// pr_alloc_ctrl_if: rename bundle, commit-return, branch-resolution and free-list signals.
interface pr_alloc_ctrl_if;
    import pr_alloc_ctrl_pkg::*;
    logic bnd_valid;
    logic [ALLOC_WIDTH-1:0] bnd_need;
    logic bnd_br;
    logic bnd_ready;
    logic [2:0] free_num;
    logic br_res_valid;
    logic [TAG_W-1:0] br_res_tag;
    logic br_res_mis;
    logic [TAG_W-1:0] ckpt_tag;
    logic [ALLOC_WIDTH-1:0] fl_need;
    logic fl_stall;
    logic fl_flush;
    ptr_t fl_flush_pos;
    ptr_t alloc_ptr;
    logic [5:0] free_cnt;
    modport master(
        output bnd_valid, bnd_need, bnd_br, free_num, br_res_valid, br_res_tag, br_res_mis,
        input bnd_ready, ckpt_tag, fl_need, fl_stall, fl_flush, fl_flush_pos, alloc_ptr, free_cnt
    );
    modport slave(
        input bnd_valid, bnd_need, bnd_br, free_num, br_res_valid, br_res_tag, br_res_mis,
        output bnd_ready, ckpt_tag, fl_need, fl_stall, fl_flush, fl_flush_pos, alloc_ptr, free_cnt
    );
endinterface

// File: rtl/pr_ckpt_queue.sv
// pr_ckpt_queue: 4-entry circular branch checkpoint queue with in-order retire and mispredict truncation.
module pr_ckpt_queue import pr_alloc_ctrl_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_en_i,
    input  logic             res_mis_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic             push_i,
    input  ptr_t             push_ptr_i,
    output logic             full_o,
    output logic             mis_o,
    output ptr_t             tag_ptr_o,
    output logic [TAG_W-1:0] tail_o
);
    typedef logic [TAG_W:0] cnt_t;
    ptr_t ptr_q [NUM_CKPT];
    ptr_t ptr_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] pend_q, pend_d;
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d, tag_dist;
    cnt_t cnt_q, cnt_d;
    logic tag_valid, retire;
    // a tag is live when its distance from head is inside the occupied span
    assign tag_dist = res_tag_i - head_q;
    assign tag_valid = cnt_t'(tag_dist) < cnt_q;
    assign retire = cnt_q != '0 && !pend_q[head_q];
    assign mis_o = res_en_i && res_mis_i && tag_valid;
    assign full_o = cnt_q == cnt_t'(NUM_CKPT);
    assign tag_ptr_o = ptr_q[res_tag_i];
    assign tail_o = tail_q;
    always_comb begin
        ptr_d = ptr_q;
        pend_d = pend_q;
        head_d = head_q + TAG_W'(retire);
        tail_d = tail_q;
        cnt_d = cnt_q - cnt_t'(retire);
        if (res_en_i && tag_valid) pend_d[res_tag_i] = 1'b0;
        if (mis_o) begin
            tail_d = res_tag_i + TAG_W'(1);
            cnt_d = cnt_t'(tag_dist) + cnt_t'(1) - cnt_t'(retire);
        end else if (push_i) begin
            ptr_d[tail_q] = push_ptr_i;
            pend_d[tail_q] = 1'b1;
            tail_d = tail_q + TAG_W'(1);
            cnt_d = cnt_q + cnt_t'(1) - cnt_t'(retire);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '{default: '0};
            pend_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            pend_q <= pend_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pr_alloc_ctrl.sv
// pr_alloc_ctrl: all-or-nothing physical register grant, free count tracking and mispredict recovery.
module pr_alloc_ctrl import pr_alloc_ctrl_pkg::*; (
    input logic           clk,
    input logic           rst_n,
    pr_alloc_ctrl_if.slave bus
);
    state_e state_q, state_d;
    ptr_t alloc_ptr_q, alloc_ptr_d, rptr_q, rptr_d, alloc_next, tag_ptr;
    logic [5:0] free_cnt_q, free_cnt_d;
    logic [7:0] free_sum;
    logic [2:0] need_cnt;
    logic [TAG_W-1:0] tail;
    logic run, grant, mis, full;
    assign run = state_q == RUN;
    assign need_cnt = 3'($countones(bus.bnd_need));
    assign alloc_next = ptr_mod(alloc_ptr_q, ptr_t'(need_cnt), 1'b0);
    assign grant = rst_n && run && bus.bnd_valid && {3'b0, need_cnt} <= free_cnt_q
                   && !(bus.bnd_br && full) && !mis;
    pr_ckpt_queue u_ckpt (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_en_i  (run && bus.br_res_valid),
        .res_mis_i (bus.br_res_mis),
        .res_tag_i (bus.br_res_tag),
        .push_i    (grant && bus.bnd_br),
        .push_ptr_i(alloc_next),
        .full_o    (full),
        .mis_o     (mis),
        .tag_ptr_o (tag_ptr),
        .tail_o    (tail)
    );
    always_comb begin
        // returns, grant and mispredict reclaim all land in one update; overflow saturates
        free_sum = 8'(free_cnt_q) + 8'(bus.free_num) - (grant ? 8'(need_cnt) : 8'd0)
                   + (mis ? 8'(ptr_mod(alloc_ptr_q, tag_ptr, 1'b1)) : 8'd0);
        free_cnt_d = free_sum > 8'(NUM_FREE_PR) ? 6'(NUM_FREE_PR) : free_sum[5:0];
        alloc_ptr_d = !run ? rptr_q : grant ? alloc_next : alloc_ptr_q;
        rptr_d = mis ? tag_ptr : rptr_q;
        state_d = mis ? RECOVER : RUN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            alloc_ptr_q <= '0;
            rptr_q <= '0;
            free_cnt_q <= 6'(NUM_FREE_PR);
        end else begin
            state_q <= state_d;
            alloc_ptr_q <= alloc_ptr_d;
            rptr_q <= rptr_d;
            free_cnt_q <= free_cnt_d;
        end
    end
    assign bus.bnd_ready = grant;
    assign bus.ckpt_tag = tail;
    assign bus.fl_need = grant ? bus.bnd_need : '0;
    assign bus.fl_flush = !run;
    assign bus.fl_stall = !grant && run;
    assign bus.fl_flush_pos = rptr_q;
    assign bus.alloc_ptr = alloc_ptr_q;
    assign bus.free_cnt = free_cnt_q;
endmodule

// File: tb/tb_pr_alloc_ctrl.sv
// tb_pr_alloc_ctrl: directed and random stimulus against a queue-based rename model, scoreboard checked.
module tb_pr_alloc_ctrl;
    import pr_alloc_ctrl_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    pr_alloc_ctrl_if bus();
    pr_alloc_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic ready, br, stall, flush;
        logic [1:0] tag;
        logic [3:0] need;
        logic [6:0] pos, alloc;
        logic [5:0] free;
    } exp_t;
    typedef struct {int tag; int ptr; bit pend;} ck_t;
    exp_t exp_q[$];
    ck_t cq[$];
    int m_free = 48, m_alloc = 0, m_rptr = 0, m_tail = 0;
    bit m_rec = 0;
    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, want, $time);
        end
    endtask
    // one clock of stimulus; the model predicts this cycle's outputs, then advances
    task automatic cyc(input logic r, input logic v, input logic [3:0] nd, input logic b,
                       input logic [2:0] fn, input logic rv, input logic [1:0] rt, input logic rm);
        exp_t e;
        int cnt, k;
        bit mis, grant, retire;
        @(negedge clk);
        rst_n = r;
        bus.bnd_valid = v;
        bus.bnd_need = nd;
        bus.bnd_br = b;
        bus.free_num = fn;
        bus.br_res_valid = rv;
        bus.br_res_tag = rt;
        bus.br_res_mis = rm;
        if (!r) begin
            m_free = 48; m_alloc = 0; m_rptr = 0; m_tail = 0; m_rec = 0;
            cq.delete();
        end
        cnt = $countones(nd);
        k = -1;
        foreach (cq[i]) if (cq[i].tag == int'(rt)) k = i;
        mis = r && !m_rec && rv && rm && k >= 0;
        grant = r && !m_rec && v && cnt <= m_free && (!b || cq.size() < 4) && !mis;
        e.ready = grant; e.br = b; e.tag = 2'(m_tail); e.need = grant ? nd : 4'h0;
        e.stall = !grant && !m_rec; e.flush = m_rec; e.pos = 7'(m_rptr);
        e.alloc = 7'(m_alloc); e.free = 6'(m_free);
        exp_q.push_back(e);
        if (!r) return;
        retire = cq.size() > 0 && !cq[0].pend;
        m_free = m_free - (grant ? cnt : 0) + int'(fn) + (mis ? (m_alloc - cq[k].ptr + 48) % 48 : 0);
        if (m_free > 48) m_free = 48;
        if (m_rec) m_alloc = m_rptr;
        else if (grant) m_alloc = (m_alloc + cnt) % 48;
        if (mis) begin
            m_rptr = cq[k].ptr;
            while (cq.size() > k + 1) void'(cq.pop_back());
            cq[k].pend = 0;
            m_tail = (int'(rt) + 1) % 4;
        end else if (!m_rec && rv && k >= 0) cq[k].pend = 0;
        m_rec = mis;
        if (retire) void'(cq.pop_front());
        if (grant && b) begin
            cq.push_back(ck_t'{m_tail, m_alloc, 1'b1});
            m_tail = (m_tail + 1) % 4;
        end
    endtask
    task automatic bund(input logic v, input logic [3:0] nd, input logic b, input logic [2:0] fn);
        cyc(1'b1, v, nd, b, fn, 1'b0, 2'd0, 1'b0);
    endtask
    task automatic res(input logic [1:0] rt, input logic rm, input logic [2:0] fn);
        cyc(1'b1, 1'b0, 4'h0, 1'b0, fn, 1'b1, rt, rm);
    endtask
    task automatic rst();
        cyc(1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bnd_ready", bus.bnd_ready, e.ready);
                chk("fl_need", bus.fl_need, e.need);
                chk("fl_stall", bus.fl_stall, e.stall);
                chk("fl_flush", bus.fl_flush, e.flush);
                chk("alloc_ptr", bus.alloc_ptr, e.alloc);
                chk("free_cnt", bus.free_cnt, e.free);
                if (e.ready && e.br) chk("ckpt_tag", bus.ckpt_tag, e.tag);
                if (e.flush) chk("fl_flush_pos", bus.fl_flush_pos, e.pos);
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bus.bnd_valid = 0; bus.bnd_need = 0; bus.bnd_br = 0; bus.free_num = 0;
        bus.br_res_valid = 0; bus.br_res_tag = 0; bus.br_res_mis = 0;
        rst(); rst();
        // twelve full bundles drain the pool and wrap the pointer
        repeat (12) bund(1, 4'hF, 0, 0);
        bund(1, 4'hF, 0, 0); #2;
        chk("drain_free", bus.free_cnt, 0);
        chk("drain_alloc", bus.alloc_ptr, 0);
        chk("drain_ready", bus.bnd_ready, 0);
        chk("drain_stall", bus.fl_stall, 1);
        bund(1, 4'h0, 0, 0); #2;
        chk("empty_bundle_ready", bus.bnd_ready, 1);
        bund(0, 4'h0, 0, 2);
        bund(1, 4'h7, 0, 1); #2;
        chk("short_ready", bus.bnd_ready, 0);
        chk("short_free", bus.free_cnt, 2);
        bund(1, 4'h7, 0, 0); #2;
        chk("refill_ready", bus.bnd_ready, 1);
        bund(0, 4'h0, 0, 0); #2;
        chk("refill_free", bus.free_cnt, 0);
        // checkpoint queue fills, then frees one slot after a correct resolve
        rst();
        for (int i = 0; i < 4; i++) begin
            bund(1, 4'h1, 1, 0); #2;
            chk("br_ready", bus.bnd_ready, 1);
            chk("br_tag", bus.ckpt_tag, i);
        end
        bund(1, 4'h1, 1, 0); #2;
        chk("full_ready", bus.bnd_ready, 0);
        chk("full_free", bus.free_cnt, 44);
        res(2'd0, 0, 0);
        bund(0, 4'h0, 0, 0);
        bund(1, 4'h1, 1, 0); #2;
        chk("reuse_ready", bus.bnd_ready, 1);
        chk("reuse_tag", bus.ckpt_tag, 0);
        // mispredict: ckpt ptr 10, alloc 22, free 20
        rst();
        for (int i = 0; i < 12; i++) bund(1, 4'hF, 0, i < 10 ? 3'd4 : (i == 10 ? 3'd2 : 3'd0));
        bund(1, 4'hF, 0, 0);
        bund(1, 4'hF, 0, 0);
        bund(1, 4'h3, 1, 0);
        bund(1, 4'hF, 1, 0);
        bund(1, 4'hF, 0, 0);
        bund(1, 4'hF, 0, 0);
        cyc(1, 1, 4'h1, 0, 0, 1, 2'd0, 1); #2;
        chk("mis_ready", bus.bnd_ready, 0);
        chk("mis_free", bus.free_cnt, 20);
        chk("mis_alloc", bus.alloc_ptr, 22);
        bund(0, 4'h0, 0, 0); #2;
        chk("rec_flush", bus.fl_flush, 1);
        chk("rec_pos", bus.fl_flush_pos, 10);
        chk("rec_free", bus.free_cnt, 32);
        cyc(1, 1, 4'h0, 1, 0, 1, 2'd1, 1); #2;
        chk("post_alloc", bus.alloc_ptr, 10);
        chk("post_ready", bus.bnd_ready, 1);
        chk("post_tag", bus.ckpt_tag, 1);
        bund(0, 4'h0, 0, 0); #2;
        chk("stale_tag_flush", bus.fl_flush, 0);
        // wrap-around reclaim plus a coincident commit return
        rst();
        repeat (11) bund(1, 4'hF, 0, 2);
        bund(1, 4'h0, 1, 0);
        bund(1, 4'hF, 0, 0);
        bund(1, 4'hF, 0, 0);
        cyc(1, 0, 4'h0, 0, 3, 1, 2'd0, 1);
        bund(0, 4'h0, 0, 0); #2;
        chk("wrap_flush", bus.fl_flush, 1);
        chk("wrap_pos", bus.fl_flush_pos, 44);
        chk("wrap_free", bus.free_cnt, 29);
        // reset during recovery
        rst();
        bund(1, 4'h1, 1, 0);
        res(2'd0, 1, 0);
        cyc(0, 1, 4'hF, 0, 0, 0, 2'd0, 0); #2;
        chk("rstrec_flush", bus.fl_flush, 0);
        chk("rstrec_ready", bus.bnd_ready, 0);
        chk("rstrec_stall", bus.fl_stall, 1);
        chk("rstrec_alloc", bus.alloc_ptr, 0);
        chk("rstrec_free", bus.free_cnt, 48);
        bund(0, 4'h0, 0, 0); #2;
        chk("release_flush", bus.fl_flush, 0);
        bund(0, 4'h0, 0, 0); #2;
        chk("release_flush2", bus.fl_flush, 0);
        chk("release_free", bus.free_cnt, 48);
        rst();
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 299) != 0, 1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0,
                3'($urandom_range(0, 4)), $urandom_range(0, 2) == 0, 2'($urandom),
                $urandom_range(0, 5) == 0);
        bund(0, 4'h0, 0, 0);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pr_alloc_ctrl.md
PR_ALLOC_CTRL -- requirements
Module: pr_alloc_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 bnd_valid  input  1  rename bundle present this cycle.
REQ-004 bnd_need  input  4  per-slot "needs destination PR" mask.
REQ-005 bnd_br  input  1  bundle ends in a branch; a checkpoint is required.
REQ-006 bnd_ready  output  1  bundle accepted this cycle (combinational grant).
REQ-007 free_num  input  3  PRs returned by commit this cycle, 0..4.
REQ-008 br_res_valid  input  1  branch resolution event.
REQ-009 br_res_tag  input  2  checkpoint tag being resolved.
REQ-010 br_res_mis  input  1  resolution is a mispredict.
REQ-011 ckpt_tag  output  2  tag assigned to the accepted branch bundle.
REQ-012 fl_need  output  4  slot mask forwarded to the free list: bnd_need when granted, else 0.
REQ-013 fl_stall  output  1  free-list stall: high whenever no grant and no flush.
REQ-014 fl_flush  output  1  one-cycle free-list pointer restore pulse.
REQ-015 fl_flush_pos  output  7  restored allocation pointer, 0..47.
REQ-016 alloc_ptr  output  7  mirrored allocation pointer, 0..47.
REQ-017 free_cnt  output  6  free PRs available, 0..48.

Function
REQ-018 Grant = state RUN & bnd_valid & popcount(bnd_need) <= free_cnt & (!bnd_br | checkpoint queue not full); all-or-nothing, no partial bundles.
REQ-019 On grant: alloc_ptr advances by popcount(bnd_need), modulo 48.
REQ-020 free_cnt_next = free_cnt - granted_count + free_num; free_num is always added, including in RECOVER and stalled cycles.
REQ-021 A free_num that would push free_cnt above 48 is a protocol error; the block saturates at 48.
REQ-022 Checkpoint queue: 4 entries, circular head/tail pointers plus a count.
REQ-023 Each checkpoint entry holds ptr (7 bits) and a pending bit.
REQ-024 Granted branch bundle: entry at tail gets ptr = post-grant alloc_ptr and pending = 1; ckpt_tag = tail; tail increments.
REQ-025 Correct resolve (br_res_valid & !br_res_mis): pending[tag] cleared.
REQ-026 Head retires one non-pending valid entry per cycle, in order.
REQ-027 Mispredict (br_res_valid & br_res_mis) in RUN transfers the FSM to RECOVER next cycle.
REQ-028 On mispredict, the block captures rptr = ckpt[tag].ptr.
REQ-029 On mispredict, tail is set to tag+1 (mod 4), discarding all younger entries; the mispredicting entry itself is retained with pending cleared.
REQ-030 On mispredict, free_cnt adds back (alloc_ptr - rptr) mod 48, applied in the same update as REQ-020.
REQ-031 A grant in the mispredict cycle is suppressed: bnd_ready = 0.
REQ-032 RECOVER (exactly 1 cycle): fl_flush = 1, fl_flush_pos = rptr, alloc_ptr <= rptr, no grants, resolution events ignored; then the FSM returns to RUN.
REQ-033 Resolve with a tag not currently valid is ignored.
REQ-034 Simultaneous grant and head retire in the same cycle are both honoured; the queue count changes by net.
REQ-035 free_cnt = 0 with any nonzero bnd_need gives no grant.
REQ-036 A bundle with bnd_need = 0 and bnd_br = 0 is always granted in RUN.

Reset
REQ-037 Asynchronous reset values: state RUN, alloc_ptr 0, free_cnt 48, queue empty, all pending bits 0, rptr 0.
REQ-038 During and immediately after reset: fl_flush 0, bnd_ready 0 while rst_n is low, fl_stall 1 while rst_n is low.
REQ-039 Reset asserted during RECOVER aborts the recovery; no flush pulse is emitted after release.

Structure
REQ-040 Shared rename package holds: NUM_FREE_PR = 48, ALLOC_WIDTH = 4, NUM_CKPT = 4, pointer width 7, the state enum {RUN, RECOVER}, and a modulo-48 add/subtract function.
REQ-041 Checkpoint queue is one sub-module: pr_ckpt_queue.
REQ-042 Grant logic, FSM and counters live at top level.

Verification
REQ-043 Directed: reset, then 12 bundles of bnd_need = 4'hF with free_num = 0 -> 12 grants; free_cnt 0; alloc_ptr 0 (wrap at 48); 13th bundle stalls, fl_stall = 1.
REQ-044 Directed: free_cnt = 2, bundle need 4'b0111 -> no grant; next cycle free_num = 1 -> grant; free_cnt 0.
REQ-045 Directed: 4 branch bundles accepted (tags 0..3) -> 5th branch bundle stalls even with free_cnt > 0; correct-resolve tag 0 -> head retires, branch accepted with tag 0.
REQ-046 Directed: checkpoint ptr 10, alloc_ptr 22, free_cnt 20, mispredict -> RECOVER next cycle, fl_flush = 1, fl_flush_pos = 10, free_cnt = 32, younger tags invalid.
REQ-047 Directed: mispredict with checkpoint ptr 44 and alloc_ptr 4 -> free_cnt += 8 (wrap-around case); mispredict coincident with free_num = 3 -> both additions applied.
REQ-048 Directed: rst_n low mid-RECOVER -> all outputs at reset values; no flush pulse after release.
